maze_loader: RTL and testbench



---
 rtl/tank_pkg.sv | 26 ++
 rtl/lfsr8.sv | 19 +
 rtl/maze_loader.sv | 118 +++++++++++
 tb/tb_maze_loader.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tank_pkg.sv
// Shared definitions for the tank game: round-status encodings, maze geometry defaults,
// wall bit positions and the maze loader state type.
package tank_pkg;

    localparam logic [1:0] GE_IN_GAME   = 2'b00;
    localparam logic [1:0] GE_NEW_ROUND = 2'b01;

    localparam int DEF_COLS      = 8;
    localparam int DEF_ROWS      = 6;
    localparam int DEF_CELL_W    = 4;
    localparam int DEF_NUM_MAZES = 4;

    localparam int WALL_N = 3;
    localparam int WALL_E = 2;
    localparam int WALL_S = 1;
    localparam int WALL_W = 0;

    // IDLE wait for request | SELECT pick layout | LOAD copy ROM to RAM | DONE hold ready
    typedef enum logic [1:0] {
        ML_IDLE   = 2'd0,
        ML_SELECT = 2'd1,
        ML_LOAD   = 2'd2,
        ML_DONE   = 2'd3
    } ml_state_t;

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, shifts every clock.
// Shared randomness source for maze selection, bullets and spawns.
module lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       CLK,
    input  logic       RESET_N,
    output logic [7:0] lfsr
);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            lfsr <= SEED;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

endmodule

// File: rtl/maze_loader.sv
// Picks a maze layout on a new-round request and copies it from the maze ROM into the wall RAM.
// Optional MAZE_LOADER_DEBUG_SEL_EN adds dbg_override/dbg_sel to force the selected layout.
module maze_loader
    import tank_pkg::*;
#(
    parameter  int COLS      = DEF_COLS,
    parameter  int ROWS      = DEF_ROWS,
    parameter  int CELL_W    = DEF_CELL_W,
    parameter  int NUM_MAZES = DEF_NUM_MAZES,
    localparam int CELLS     = COLS * ROWS,
    localparam int CA_W      = $clog2(CELLS),
    localparam int MI_W      = $clog2(NUM_MAZES),
    localparam int RA_W      = $clog2(NUM_MAZES * CELLS)
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [1:0]        game_end,
    output logic [RA_W-1:0]   rom_addr,
    input  logic [CELL_W-1:0] rom_data,
    output logic              wall_we,
    output logic [CA_W-1:0]   wall_addr,
    output logic [CELL_W-1:0] wall_data,
    output logic [MI_W-1:0]   maze_idx,
    output logic              maze_ready
`ifdef MAZE_LOADER_DEBUG_SEL_EN
    ,
    input  logic              dbg_override,
    input  logic [MI_W-1:0]   dbg_sel
`endif
);

    ml_state_t         state, state_nx;
    logic [7:0]        lfsr;
    logic              req;
    logic [MI_W-1:0]   prev_idx;
    logic [MI_W-1:0]   cand;
    logic [MI_W-1:0]   sel_idx;
    logic [CA_W:0]     rd_cnt;
    logic              issue;
    logic [RA_W-1:0]   rd_addr;
    logic [RA_W-1:0]   rom_addr_q;
    logic              wr_vld;
    logic [CA_W-1:0]   wr_addr;
    logic              wr_last;
    logic              unused_lfsr_hi;

    lfsr8 #(.SEED(8'hA5)) u_lfsr (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .lfsr    (lfsr)
    );

    assign unused_lfsr_hi = ^lfsr[7:MI_W];

    assign req     = (game_end == GE_NEW_ROUND);
    assign cand    = lfsr[MI_W-1:0];
    assign issue   = (state == ML_LOAD) && (rd_cnt < (CA_W+1)'(CELLS));
    assign rd_addr = RA_W'(prev_idx) * RA_W'(CELLS) + RA_W'(rd_cnt);
    assign wr_last = wr_vld && (wr_addr == CA_W'(CELLS - 1));

    always_comb begin
        sel_idx = (cand == prev_idx) ? cand + MI_W'(1) : cand;
`ifdef MAZE_LOADER_DEBUG_SEL_EN
        if (dbg_override) begin
            sel_idx = dbg_sel;
        end
`endif
    end

    always_comb begin
        state_nx = state;
        case (state)
            ML_IDLE:   if (req) state_nx = ML_SELECT;
            ML_SELECT: state_nx = req ? ML_LOAD : ML_IDLE;
            ML_LOAD: begin
                if (!req) begin
                    state_nx = ML_IDLE;
                end else if (wr_last) begin
                    state_nx = ML_DONE;
                end
            end
            ML_DONE:   if (!req) state_nx = ML_IDLE;
            default:   state_nx = ML_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= ML_IDLE;
            prev_idx   <= '0;
            rd_cnt     <= '0;
            rom_addr_q <= '0;
            wr_vld     <= 1'b0;
            wr_addr    <= '0;
        end else begin
            state   <= state_nx;
            // an abort drops the in-flight read instead of writing it
            wr_vld  <= issue && req;
            wr_addr <= rd_cnt[CA_W-1:0];
            if (issue) begin
                rd_cnt     <= rd_cnt + (CA_W+1)'(1);
                rom_addr_q <= rd_addr;
            end
            if (state == ML_SELECT) begin
                prev_idx <= sel_idx;
                rd_cnt   <= '0;
            end
        end
    end

    assign rom_addr   = issue ? rd_addr : rom_addr_q;
    assign wall_we    = wr_vld;
    assign wall_addr  = wr_addr;
    assign wall_data  = wr_vld ? rom_data : '0;
    assign maze_idx   = prev_idx;
    assign maze_ready = (state == ML_DONE);

endmodule

// File: tb/tb_maze_loader.sv
// Directed bench for maze_loader: cycle-timeline model of a load round plus literal checks.
// Define MAZE_LOADER_DEBUG_SEL_EN on both RTL and bench to exercise the forced-selection ports.
module tb_maze_loader;

    localparam int CELLS     = 48;
    localparam int NUM_MAZES = 4;
    localparam int MI_W      = 2;
    localparam int RA_W      = 8;
    localparam int CA_W      = 6;
    localparam int CELL_W    = 4;

    logic              CLK = 1'b0;
    logic              RESET_N = 1'b0;
    logic [1:0]        game_end = 2'b00;
    logic [RA_W-1:0]   rom_addr;
    logic [CELL_W-1:0] rom_data;
    logic              wall_we;
    logic [CA_W-1:0]   wall_addr;
    logic [CELL_W-1:0] wall_data;
    logic [MI_W-1:0]   maze_idx;
    logic              maze_ready;
`ifdef MAZE_LOADER_DEBUG_SEL_EN
    logic              dbg_override = 1'b0;
    logic [MI_W-1:0]   dbg_sel = '0;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    maze_loader u_dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .game_end   (game_end),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .wall_we    (wall_we),
        .wall_addr  (wall_addr),
        .wall_data  (wall_data),
        .maze_idx   (maze_idx),
        .maze_ready (maze_ready)
`ifdef MAZE_LOADER_DEBUG_SEL_EN
        ,
        .dbg_override (dbg_override),
        .dbg_sel      (dbg_sel)
`endif
    );

    // synchronous ROM whose contents are the low address bits
    logic [CELL_W-1:0] rom_q = '0;
    always @(posedge CLK) rom_q <= rom_addr[CELL_W-1:0];
    assign rom_data = rom_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic logic [1:0] pick(input logic [7:0] l, input logic [1:0] prev);
        int c;
        c = int'(l) % NUM_MAZES;
        if (c == int'(prev)) c = (c + 1) % NUM_MAZES;
        return 2'(c);
    endfunction

    // Model: m_k counts clocks since the edge that accepted the request.
    // k=0 selection, k=1..48 reads, k=2..49 writes, k>=50 ready.
    logic [7:0] m_lfsr;
    bit         m_busy;
    int         m_k;
    logic [1:0] m_idx, m_pend;
    int         m_hold;

    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            m_lfsr <= 8'hA5;
            m_busy <= 1'b0;
            m_k    <= 0;
            m_idx  <= 2'd0;
            m_pend <= 2'd0;
            m_hold <= 0;
        end else begin
            m_lfsr <= lfsr_next(m_lfsr);
            if (m_busy && m_k >= 1 && m_k <= CELLS) m_hold <= int'(m_idx) * CELLS + m_k - 1;
            if (m_busy && m_k == 0) m_idx <= m_pend;
            if (!m_busy) begin
                if (game_end == 2'b01) begin
                    m_busy <= 1'b1;
                    m_k    <= 0;
                    m_pend <= pick(lfsr_next(m_lfsr), m_idx);
`ifdef MAZE_LOADER_DEBUG_SEL_EN
                    if (dbg_override) m_pend <= dbg_sel;
`endif
                end
            end else if (game_end != 2'b01) begin
                m_busy <= 1'b0;
            end else if (m_k < 100) begin
                m_k <= m_k + 1;
            end
        end
    end

    always @(negedge CLK) begin
        bit exp_we;
        int exp_rom;
        if (RESET_N) begin
            exp_we  = m_busy && m_k >= 2 && m_k <= CELLS + 1;
            exp_rom = (m_busy && m_k >= 1 && m_k <= CELLS) ? int'(m_idx) * CELLS + m_k - 1 : m_hold;
            chk("maze_ready", 32'(maze_ready), 32'(m_busy && m_k >= CELLS + 2));
            chk("wall_we", 32'(wall_we), 32'(exp_we));
            chk("maze_idx", 32'(maze_idx), 32'(m_idx));
            chk("rom_addr", 32'(rom_addr), exp_rom);
            if (exp_we) begin
                chk("wall_addr", 32'(wall_addr), m_k - 2);
                chk("wall_data", 32'(wall_data), (int'(m_idx) * CELLS + m_k - 2) % 16);
            end
        end
    end

    int wr_total = 0;
    always @(negedge CLK) if (RESET_N && wall_we) wr_total <= wr_total + 1;

    task automatic chk_all_zero(input string tag);
        chk({tag, " rom_addr"}, 32'(rom_addr), 0);
        chk({tag, " wall_we"}, 32'(wall_we), 0);
        chk({tag, " wall_addr"}, 32'(wall_addr), 0);
        chk({tag, " wall_data"}, 32'(wall_data), 0);
        chk({tag, " maze_idx"}, 32'(maze_idx), 0);
        chk({tag, " maze_ready"}, 32'(maze_ready), 0);
    endtask

    // Full round from IDLE: request, wait for ready, drop request one cycle later.
    task automatic do_round(input string tag, output logic [1:0] idx,
                            output int first_rom, output int last_rom);
        int c;
        int w0;
        bit got;
        @(negedge CLK);
        game_end = 2'b01;
        w0 = wr_total;
        @(posedge CLK);
        @(posedge CLK);
        #1 first_rom = int'(rom_addr);
        c   = 1;
        got = 1'b0;
        while (c < 200 && !got) begin
            @(posedge CLK);
            #1 c++;
            if (maze_ready) got = 1'b1;
        end
        chk({tag, " latency"}, c, 50);
        chk({tag, " writes"}, wr_total - w0, 48);
        idx      = maze_idx;
        last_rom = int'(rom_addr);
        chk({tag, " rom span"}, last_rom - first_rom, 47);
        @(posedge CLK);
        @(negedge CLK);
        game_end = 2'b00;
        @(posedge CLK);
        #1 chk({tag, " ready drop"}, 32'(maze_ready), 0);
    endtask

    initial begin
        logic [1:0] idx, prev;
        int fr, lr, w, c;
        bit got;

        RESET_N  = 1'b0;
        game_end = 2'b00;
        #1 chk_all_zero("reset");
        repeat (3) @(negedge CLK);
        #2 RESET_N = 1'b1;

        repeat (20) @(negedge CLK);
        chk("idle ready", 32'(maze_ready), 0);
        chk("idle idx", 32'(maze_idx), 0);
        chk("idle writes", wr_total, 0);

        do_round("round0", idx, fr, lr);
        prev = idx;
        for (int i = 0; i < 16; i++) begin
            repeat (i % 3) @(negedge CLK);
            do_round("roundN", idx, fr, lr);
            chk("no repeat", 32'(idx != prev), 1);
            prev = idx;
        end

        // abort after the 10th write
        @(negedge CLK);
        game_end = 2'b01;
        w = 0;
        c = 0;
        while (w < 10 && c < 200) begin
            @(negedge CLK);
            c++;
            if (wall_we) w++;
        end
        chk("abort reached 10 writes", w, 10);
        game_end = 2'b10;
        @(negedge CLK);
        chk("abort wall_we", 32'(wall_we), 0);
        chk("abort ready", 32'(maze_ready), 0);
        repeat (5) @(negedge CLK);
        game_end = 2'b00;
        do_round("rerequest", idx, fr, lr);

        // abort during selection
        @(negedge CLK) game_end = 2'b01;
        @(negedge CLK) game_end = 2'b00;
        repeat (3) @(negedge CLK);
        do_round("after sel abort", idx, fr, lr);

        // async reset mid-load, twice, must reselect the same layout
        @(negedge CLK) game_end = 2'b01;
        for (int r = 0; r < 2; r++) begin
            repeat (20) @(posedge CLK);
            #3 RESET_N = 1'b0;
            #1 chk_all_zero("async reset");
            @(negedge CLK);
            #2 RESET_N = 1'b1;
            @(posedge CLK);
            @(posedge CLK);
            #1 chk("post-reset idx", 32'(maze_idx), 2);
            chk("post-reset rom", 32'(rom_addr), 96);
        end
        got = 1'b0;
        c = 0;
        while (c < 200 && !got) begin
            @(posedge CLK);
            #1 c++;
            if (maze_ready) got = 1'b1;
        end
        chk("post-reset ready", 32'(got), 1);
        @(negedge CLK) game_end = 2'b00;
        repeat (3) @(negedge CLK);

`ifdef MAZE_LOADER_DEBUG_SEL_EN
        dbg_override = 1'b1;
        dbg_sel      = 2'd2;
        for (int r = 0; r < 2; r++) begin
            do_round("dbg", idx, fr, lr);
            chk("dbg idx", 32'(idx), 2);
            chk("dbg first rom", fr, 96);
            chk("dbg last rom", lr, 143);
        end
        dbg_override = 1'b0;
`endif

        repeat (3) @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
